// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and IMEM.
// The fetch side holds imem_addr steady from the first imem_req cycle until imem_ack.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [ADDR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs the IMEM req/ack handshake,
// feeds decode through an output register plus a one-entry skid buffer.
module fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallD,
  input  logic              PCsrcE,
  input  logic [ADDR_W-1:0] PCbranchE,
  fetch_ctrl_if.master      imem,
  output logic              validD,
  output logic [ADDR_W-1:0] instrD,
  output logic [ADDR_W-1:0] PCD,
  output logic [1:0]        fetch_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FULL  = 2'd3;

  logic [1:0]        stateReg, stateNext;
  logic [ADDR_W-1:0] pcFReg, pcFNext;
  logic [ADDR_W-1:0] drainAddrReg, drainAddrNext;
  logic              validReg, validNext;
  logic [ADDR_W-1:0] instrReg, instrNext;
  logic [ADDR_W-1:0] pcDReg, pcDNext;
  logic              skidValidReg, skidValidNext;
  logic [ADDR_W-1:0] skidInstrReg, skidInstrNext;
  logic [ADDR_W-1:0] skidPcReg, skidPcNext;

  logic              consume;
  logic              outFree;
  logic [ADDR_W-1:0] redirectTarget;

  assign consume        = validReg && !stallD;
  // Output slot is reusable this cycle only if decode takes it and the skid is not refilling it.
  assign outFree        = !validReg || (consume && !skidValidReg);
  assign redirectTarget = PCbranchE & ~ADDR_W'(3);

  always_comb begin
    stateNext     = stateReg;
    pcFNext       = pcFReg;
    drainAddrNext = drainAddrReg;
    validNext     = validReg;
    instrNext     = instrReg;
    pcDNext       = pcDReg;
    skidValidNext = skidValidReg;
    skidInstrNext = skidInstrReg;
    skidPcNext    = skidPcReg;

    if (PCsrcE) begin
      validNext     = 1'b0;
      skidValidNext = 1'b0;
      pcFNext       = redirectTarget;
      case (stateReg)
        FETCH: begin
          // Without an ack the request must still complete at its old address.
          if (!imem.imem_ack) begin
            stateNext     = DRAIN;
            drainAddrNext = pcFReg;
          end
        end
        DRAIN:   stateNext = DRAIN;
        default: stateNext = FETCH;
      endcase
    end else begin
      if (consume) begin
        if (skidValidReg) begin
          instrNext     = skidInstrReg;
          pcDNext       = skidPcReg;
          skidValidNext = 1'b0;
        end else begin
          validNext = 1'b0;
        end
      end

      case (stateReg)
        IDLE: stateNext = FETCH;
        FETCH: begin
          if (imem.imem_ack) begin
            pcFNext = pcFReg + ADDR_W'(4);
            if (outFree) begin
              validNext = 1'b1;
              instrNext = imem.imem_rdata;
              pcDNext   = pcFReg;
            end else begin
              skidValidNext = 1'b1;
              skidInstrNext = imem.imem_rdata;
              skidPcNext    = pcFReg;
            end
            if (validNext && skidValidNext) stateNext = FULL;
          end
        end
        DRAIN: begin
          if (imem.imem_ack) stateNext = FETCH;
        end
        default: begin
          if (!skidValidNext) stateNext = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg     <= IDLE;
      pcFReg       <= RESET_PC;
      drainAddrReg <= RESET_PC;
      validReg     <= 1'b0;
      instrReg     <= '0;
      pcDReg       <= '0;
      skidValidReg <= 1'b0;
      skidInstrReg <= '0;
      skidPcReg    <= '0;
    end else begin
      stateReg     <= stateNext;
      pcFReg       <= pcFNext;
      drainAddrReg <= drainAddrNext;
      validReg     <= validNext;
      instrReg     <= instrNext;
      pcDReg       <= pcDNext;
      skidValidReg <= skidValidNext;
      skidInstrReg <= skidInstrNext;
      skidPcReg    <= skidPcNext;
    end
  end

  assign imem.imem_req  = (stateReg == FETCH) || (stateReg == DRAIN);
  assign imem.imem_addr = (stateReg == DRAIN) ? drainAddrReg : pcFReg;
  assign validD         = validReg;
  assign instrD         = instrReg;
  assign PCD            = pcDReg;
  assign fetch_state    = stateReg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural IMEM of programmable latency.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stallD;
  logic        PCsrcE;
  logic [31:0] PCbranchE;
  logic        validD;
  logic [31:0] instrD;
  logic [31:0] PCD;
  logic [1:0]  fetch_state;

  int checks = 0;
  int errors = 0;
  int lat    = 0;
  int waitCnt;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .stallD     (stallD),
    .PCsrcE     (PCsrcE),
    .PCbranchE  (PCbranchE),
    .imem       (bus),
    .validD     (validD),
    .instrD     (instrD),
    .PCD        (PCD),
    .fetch_state(fetch_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IMEM model: acks on the (lat+1)-th cycle of a held request, data = addr ^ A5A5_0000.
  assign bus.imem_ack   = bus.imem_req && (waitCnt >= lat);
  assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) waitCnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  always @(negedge clk)
    if (rst && validD && !stallD)
      $display("decode PCD=%h instrD=%h", PCD, instrD);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; stallD = 1'b0; PCsrcE = 1'b0; PCbranchE = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stallD = 1'b0; PCsrcE = 1'b0; PCbranchE = '0; lat = 0;
    step();
    step();
    checks++;
    if ({fetch_state, bus.imem_req, bus.imem_addr, validD, instrD, PCD} !== {2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_values: got state=%0d req=%b addr=%h valid=%b instr=%h pcd=%h, want 0 0 0 0 0 0",
               fetch_state, bus.imem_req, bus.imem_addr, validD, instrD, PCD);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (fetch_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got state=%0d want 0", fetch_state);
    end
    step();
    checks++;
    if ({fetch_state, bus.imem_req, bus.imem_addr} !== {2'd1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL first_fetch: got state=%0d req=%b addr=%h want 1 1 00000000", fetch_state, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    lat = 0;
    apply_reset();
    step();
    checks++;
    if ({fetch_state, bus.imem_req, bus.imem_addr, validD} !== {2'd1, 1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL zw_first_req: got state=%0d req=%b addr=%h valid=%b", fetch_state, bus.imem_req, bus.imem_addr, validD);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({validD, PCD, instrD} !== {1'b1, 32'(4 * i), 32'(4 * i) ^ 32'hA5A5_0000}) begin
        errors++;
        $display("FAIL zw_seq[%0d]: got valid=%b pcd=%h instr=%h want 1 %h %h",
                 i, validD, PCD, instrD, 32'(4 * i), 32'(4 * i) ^ 32'hA5A5_0000);
      end
    end
  endtask

  task automatic test_stall();
    lat = 0;
    apply_reset();
    repeat (4) step();
    checks++;
    if ({validD, PCD} !== {1'b1, 32'h8}) begin
      errors++;
      $display("FAIL stall_setup: got valid=%b pcd=%h want 1 00000008", validD, PCD);
    end
    stallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({fetch_state, bus.imem_req, validD, PCD, instrD} !== {2'd3, 1'b0, 1'b1, 32'h8, 32'hA5A5_0008}) begin
        errors++;
        $display("FAIL stall_full[%0d]: got state=%0d req=%b valid=%b pcd=%h instr=%h want 3 0 1 00000008 a5a50008",
                 i, fetch_state, bus.imem_req, validD, PCD, instrD);
      end
    end
    stallD = 1'b0;
    step();
    checks++;
    if ({fetch_state, validD, PCD, instrD, bus.imem_addr} !== {2'd1, 1'b1, 32'hC, 32'hA5A5_000C, 32'h10}) begin
      errors++;
      $display("FAIL stall_release_skid: got state=%0d valid=%b pcd=%h instr=%h addr=%h want 1 1 0000000c a5a5000c 00000010",
               fetch_state, validD, PCD, instrD, bus.imem_addr);
    end
    step();
    checks++;
    if ({validD, PCD} !== {1'b1, 32'h10}) begin
      errors++;
      $display("FAIL stall_release_next: got valid=%b pcd=%h want 1 00000010", validD, PCD);
    end
  endtask

  task automatic test_latency();
    lat = 3;
    apply_reset();
    step();
    for (int n = 0; n < 3; n++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        checks++;
        if ({bus.imem_req, bus.imem_addr, validD} !== {1'b1, 32'(4 * n), 1'b0}) begin
          errors++;
          $display("FAIL lat_hold[%0d.%0d]: got req=%b addr=%h valid=%b want 1 %h 0",
                   n, c, bus.imem_req, bus.imem_addr, validD, 32'(4 * n));
        end
      end
      step();
      checks++;
      if ({validD, PCD, instrD, bus.imem_addr} !== {1'b1, 32'(4 * n), 32'(4 * n) ^ 32'hA5A5_0000, 32'(4 * n + 4)}) begin
        errors++;
        $display("FAIL lat_deliver[%0d]: got valid=%b pcd=%h instr=%h addr=%h want 1 %h",
                 n, validD, PCD, instrD, bus.imem_addr, 32'(4 * n));
      end
    end
  endtask

  task automatic test_redirect_drain();
    bit badDecode = 0;
    bit badAddr   = 0;
    lat = 3;
    apply_reset();
    for (int i = 0; i < 60 && !(fetch_state == 2'd1 && bus.imem_addr == 32'h10); i++) step();
    checks++;
    if ({fetch_state, bus.imem_addr, waitCnt} !== {2'd1, 32'h10, 32'd0}) begin
      errors++;
      $display("FAIL drain_setup: got state=%0d addr=%h wait=%0d want 1 00000010 0", fetch_state, bus.imem_addr, waitCnt);
    end
    PCsrcE = 1'b1; PCbranchE = 32'h0000_0103;
    step();
    PCsrcE = 1'b0;
    checks++;
    if ({fetch_state, bus.imem_req, bus.imem_addr, validD} !== {2'd2, 1'b1, 32'h10, 1'b0}) begin
      errors++;
      $display("FAIL drain_enter: got state=%0d req=%b addr=%h valid=%b want 2 1 00000010 0",
               fetch_state, bus.imem_req, bus.imem_addr, validD);
    end
    for (int i = 0; i < 10 && fetch_state == 2'd2; i++) begin
      if (validD) badDecode = 1;
      if (bus.imem_addr !== 32'h10) badAddr = 1;
      step();
    end
    checks++;
    if ({badDecode, badAddr} !== 2'b00) begin
      errors++;
      $display("FAIL drain_hold: got validDuringDrain=%b addrMoved=%b want 0 0", badDecode, badAddr);
    end
    checks++;
    if ({fetch_state, bus.imem_addr, validD} !== {2'd1, 32'h100, 1'b0}) begin
      errors++;
      $display("FAIL drain_exit: got state=%0d addr=%h valid=%b want 1 00000100 0", fetch_state, bus.imem_addr, validD);
    end
    for (int i = 0; i < 10 && !validD; i++) step();
    checks++;
    if ({validD, PCD, instrD} !== {1'b1, 32'h100, 32'hA5A5_0100}) begin
      errors++;
      $display("FAIL drain_target: got valid=%b pcd=%h instr=%h want 1 00000100 a5a50100", validD, PCD, instrD);
    end
  endtask

  task automatic test_redirect_ack();
    lat = 0;
    apply_reset();
    step();
    step();
    stallD = 1'b1; PCsrcE = 1'b1; PCbranchE = 32'h0000_0202;
    step();
    PCsrcE = 1'b0;
    checks++;
    if ({validD, fetch_state, bus.imem_addr} !== {1'b0, 2'd1, 32'h200}) begin
      errors++;
      $display("FAIL redir_ack: got valid=%b state=%0d addr=%h want 0 1 00000200", validD, fetch_state, bus.imem_addr);
    end
    step();
    checks++;
    if ({validD, PCD, fetch_state} !== {1'b1, 32'h200, 2'd1}) begin
      errors++;
      $display("FAIL redir_skid_empty: got valid=%b pcd=%h state=%0d want 1 00000200 1", validD, PCD, fetch_state);
    end
    step();
    stallD = 1'b0;
    step();
    checks++;
    if ({validD, PCD} !== {1'b1, 32'h204}) begin
      errors++;
      $display("FAIL redir_follow: got valid=%b pcd=%h want 1 00000204", validD, PCD);
    end
  endtask

  task automatic test_reset_mid_drain();
    lat = 0;
    apply_reset();
    repeat (3) step();
    lat = 3; PCsrcE = 1'b1; PCbranchE = 32'h0000_0040;
    step();
    PCsrcE = 1'b0;
    checks++;
    if ({fetch_state, bus.imem_addr, instrD} !== {2'd2, 32'h8, 32'hA5A5_0004}) begin
      errors++;
      $display("FAIL rst_drain_setup: got state=%0d addr=%h instr=%h want 2 00000008 a5a50004", fetch_state, bus.imem_addr, instrD);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({fetch_state, bus.imem_req, bus.imem_addr, validD, instrD, PCD} !== {2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL rst_async: got state=%0d req=%b addr=%h valid=%b instr=%h pcd=%h want all zero",
               fetch_state, bus.imem_req, bus.imem_addr, validD, instrD, PCD);
    end
    step();
    rst = 1'b1; lat = 0;
    step();
    step();
    checks++;
    if ({validD, PCD, instrD} !== {1'b1, 32'h0, 32'hA5A5_0000}) begin
      errors++;
      $display("FAIL rst_restart: got valid=%b pcd=%h instr=%h want 1 00000000 a5a50000", validD, PCD, instrD);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_latency();
    test_redirect_drain();
    test_redirect_ack();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
